// File: rtl/pci_target_top.sv
// -----------------------------------------------------------------------------
// pci_target_top
//
// PCI-style 32-bit bus target backed by a 256 x 32 memory and claimed on a
// 1 KiB window (AD[31:10] == BASE_ADDR). Memory read/write commands are
// decoded and burst transfers are performed with IRDY/TRDY wait states.
// Supports linear and 4-word cache-line-wrap bursts, plus disconnect-with-data
// at the top of the window or for reserved burst modes.
//
// Handshake: a data transfer happens on a rising CLK edge where I_RDY==0 and
// T_RDY==0 (both active low). I_RDY==1 is a master wait state: the word
// pointer holds and read data on AD stays stable. The last data phase is the
// one transferred with FRAME==1.
//
// Ports:
//   CLK         in     system clock, rising-edge sampled
//   RST         in     asynchronous active-high reset
//   AD[31:0]    inout  address/data; driven by this block only in RDATA
//   C_BE[3:0]   inout  command / active-low byte enables; never driven here
//   FRAME       in     active-low transaction framing
//   I_RDY       in     active-low initiator ready
//   T_RDY       out    active-low target ready
//   STOP        out    active-low target stop (disconnect)
//   DEV_SEL     out    active-low device select
//   perr        out    active-low stored-parity error (one clock)
//   par         out    even parity of the previous RDATA cycle's AD and C_BE
//   dbg_state_o out    current FSM state (0 IDLE,1 WDATA,2 TURN,3 RDATA,4 DISC)
//
// Configuration macro: PARITY_EN
//   defined   -> per-word parity bit stored (33-bit memory), par/perr active
//   undefined -> no parity storage, par tied 0, perr tied 1
// -----------------------------------------------------------------------------
module pci_target_top #(
   parameter logic [21:0] BASE_ADDR = 22'h0
) (
   input  logic        CLK,
   input  logic        RST,
   inout  wire  [31:0] AD,
   inout  wire  [3:0]  C_BE,
   input  logic        FRAME,
   input  logic        I_RDY,
   output logic        T_RDY,
   output logic        STOP,
   output logic        DEV_SEL,
   output logic        perr,
   output logic        par,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WDATA = 3'd1,
      ST_TURN  = 3'd2,
      ST_RDATA = 3'd3,
      ST_DISC  = 3'd4
   } state_t;

`ifdef PARITY_EN
   localparam int MW = 33;
`else
   localparam int MW = 32;
`endif

   state_t       state_q, state_d;
   logic [7:0]   ptr_q, ptr_d;
   logic [1:0]   mode_q, mode_d;
   logic [MW-1:0] mem_q [256];

   logic         is_wr_cmd, is_rd_cmd, hit, claim;
   logic         data_phase, xfer, disc_cond, wr_en;
   logic [7:0]   ptr_nxt;
   logic [MW-1:0] rd_ent;
   logic [31:0]  rd_word, wr_word;
   logic [MW-1:0] wr_ent;

   // ---------------- address-phase decode ----------------
   assign is_wr_cmd = (C_BE == 4'b0111) || (C_BE == 4'b1111);
   assign is_rd_cmd = (C_BE == 4'b0110) || (C_BE == 4'b1100) || (C_BE == 4'b1110);
   assign hit       = (AD[31:10] == BASE_ADDR);
   assign claim     = !FRAME && hit && (is_wr_cmd || is_rd_cmd);

   // ---------------- data-phase qualifiers ----------------
   assign data_phase = (state_q == ST_WDATA) || (state_q == ST_RDATA);
   assign xfer       = data_phase && !I_RDY;
   // Linear bursts cannot run past word 255; reserved modes (x1) stop after
   // the first word.
   assign disc_cond  = mode_q[0] || ((mode_q == 2'b00) && (ptr_q == 8'hFF));
   assign wr_en      = (state_q == ST_WDATA) && !I_RDY;

   // Wrap mode only rotates the low two bits, staying in the aligned line.
   assign ptr_nxt = mode_q[1] ? {ptr_q[7:2], ptr_q[1:0] + 2'd1} : ptr_q + 8'd1;

   // ---------------- memory ----------------
   assign rd_ent  = mem_q[ptr_q];
   assign rd_word = rd_ent[31:0];

   always_comb begin
      wr_word = rd_word;
      for (int i = 0; i < 4; i++) begin
         if (!C_BE[i]) wr_word[8*i +: 8] = AD[8*i +: 8];
      end
   end

`ifdef PARITY_EN
   assign wr_ent = {^wr_word, wr_word};
`else
   assign wr_ent = wr_word;
`endif

   // Contents are intentionally not reset.
   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[ptr_q] <= wr_ent;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ptr_q   <= 8'd0;
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mode_q  <= mode_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (claim) begin
               ptr_d   = AD[9:2];
               mode_d  = AD[1:0];
               state_d = is_wr_cmd ? ST_WDATA : ST_TURN;
            end
         end
         ST_TURN: state_d = ST_RDATA;
         ST_WDATA, ST_RDATA: begin
            if (xfer) begin
               ptr_d = ptr_nxt;
               // A last phase that also hits the disconnect point ends cleanly.
               if (FRAME)          state_d = ST_IDLE;
               else if (disc_cond) state_d = ST_DISC;
            end
         end
         ST_DISC: begin
            if (FRAME) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      T_RDY   = 1'b1;
      STOP    = 1'b1;
      DEV_SEL = 1'b1;
      case (state_q)
         ST_WDATA, ST_RDATA: begin
            T_RDY   = 1'b0;
            DEV_SEL = 1'b0;
            STOP    = !disc_cond;
         end
         ST_TURN: DEV_SEL = 1'b0;
         ST_DISC: begin
            DEV_SEL = 1'b0;
            STOP    = 1'b0;
         end
         default: ;
      endcase
   end

   assign dbg_state_o = state_q;

   // AD is only ours once the turnaround cycle has passed.
   assign AD   = (state_q == ST_RDATA) ? rd_word : 32'hzzzz_zzzz;
   assign C_BE = 4'bzzzz;

   // ---------------- parity ----------------
`ifdef PARITY_EN
   logic par_q, par_d, perr_q, perr_d;

   assign par_d  = (state_q == ST_RDATA) ? (^rd_word ^ ^C_BE) : 1'b0;
   assign perr_d = !((state_q == ST_RDATA) && !I_RDY && (^rd_word != rd_ent[32]));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         par_q  <= 1'b0;
         perr_q <= 1'b1;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end

   assign par  = par_q;
   assign perr = perr_q;
`else
   assign par  = 1'b0;
   assign perr = 1'b1;
`endif

endmodule

// File: tb/tb_pci_target_top.sv
module tb_pci_target_top;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame, irdy;
   logic [31:0] ad_drv;
   logic        ad_en;
   logic [3:0]  cbe_drv;
   wire  [31:0] ad_w;
   wire  [3:0]  cbe_w;
   logic        t_rdy, stop, dev_sel, perr, par;
   logic [2:0]  dbg_state;

   assign ad_w  = ad_en ? ad_drv : 32'hzzzz_zzzz;
   assign cbe_w = cbe_drv;

   pci_target_top dut (
      .CLK         (clk),
      .RST         (rst),
      .AD          (ad_w),
      .C_BE        (cbe_w),
      .FRAME       (frame),
      .I_RDY       (irdy),
      .T_RDY       (t_rdy),
      .STOP        (stop),
      .DEV_SEL     (dev_sel),
      .perr        (perr),
      .par         (par),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   // reference model
   logic [31:0] model_mem [256];
   logic [31:0] wr_data [256];
   logic [3:0]  wr_be   [256];
   logic        wr_wait [256];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Word addressed by data phase k of a burst starting at word 'start'.
   function automatic int word_at(input int start, input logic [1:0] mode, input int k);
      if (mode == 2'b10) return (start / 4) * 4 + (start + k) % 4;
      return (start + k) % 256;
   endfunction

   // Nobody is driving AD (z in 4-state, 0 when resolved 2-state).
   function automatic logic ad_released();
      return ($countones(ad_w) == 0);
   endfunction

   function automatic logic exp_parity(input logic [31:0] w, input logic [3:0] be);
`ifdef PARITY_EN
      return ^w ^ ^be;
`else
      return 1'b0 & (^w ^ ^be);
`endif
   endfunction

   task automatic clear_wr();
      for (int i = 0; i < 256; i++) begin
         wr_data[i] = 32'h0;
         wr_be[i]   = 4'h0;
         wr_wait[i] = 1'b0;
      end
   endtask

   task automatic wr_burst(input logic [31:0] addr, input logic [3:0] cmd, input int n);
      int start;
      logic [1:0] mode;
      int w;
      start = int'(addr[9:2]);
      mode  = addr[1:0];
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; ad_en = 1'b1; ad_drv = addr; cbe_drv = cmd;
      for (int k = 0; k < n; k++) begin
         if (wr_wait[k]) begin
            @(negedge clk);
            check("wr_wait_trdy", 32'(t_rdy), 32'd0);
            irdy = 1'b1; frame = 1'b0; ad_drv = 32'hFFFF_FFFF; cbe_drv = 4'h0;
         end
         @(negedge clk);
         check("wr_devsel", 32'(dev_sel), 32'd0);
         check("wr_trdy", 32'(t_rdy), 32'd0);
         check("wr_stop", 32'(stop), 32'd1);
         ad_drv = wr_data[k]; cbe_drv = wr_be[k]; irdy = 1'b0; frame = (k == n - 1);
         w = word_at(start, mode, k);
         for (int b = 0; b < 4; b++)
            if (!wr_be[k][b]) model_mem[w][8*b +: 8] = wr_data[k][8*b +: 8];
      end
      @(negedge clk);
      check("wr_end_devsel", 32'(dev_sel), 32'd1);
      check("wr_end_trdy", 32'(t_rdy), 32'd1);
      frame = 1'b1; irdy = 1'b1; ad_en = 1'b0;
   endtask

   task automatic rd_burst(input logic [31:0] addr, input logic [3:0] cmd, input int n);
      int start, k, waits;
      logic [1:0] mode;
      logic [31:0] w;
      logic ep;
      start = int'(addr[9:2]);
      mode  = addr[1:0];
      k = 0; waits = 0; ep = 1'b0;
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; ad_en = 1'b1; ad_drv = addr; cbe_drv = cmd;
      @(negedge clk);
      ad_en = 1'b0; irdy = 1'b0; frame = (n == 1); cbe_drv = 4'($urandom);
      #1;
      check("rd_turn_devsel", 32'(dev_sel), 32'd0);
      check("rd_turn_trdy", 32'(t_rdy), 32'd1);
      check("rd_turn_ad_off", 32'(ad_released()), 32'd1);
      while (k < n) begin
         @(negedge clk);
         w = model_mem[word_at(start, mode, k)];
         check("rd_data", ad_w, w);
         check("rd_trdy", 32'(t_rdy), 32'd0);
         check("rd_devsel", 32'(dev_sel), 32'd0);
         check("rd_stop", 32'(stop), 32'd1);
         check("rd_par", 32'(par), 32'(ep));
         check("rd_perr", 32'(perr), 32'd1);
         cbe_drv = 4'($urandom);
         ep = exp_parity(w, cbe_drv);
         if (waits < 4 && $urandom_range(0, 3) == 0) begin
            irdy = 1'b1; frame = 1'b0; waits++;
         end else begin
            irdy = 1'b0; frame = (k == n - 1); k++;
         end
      end
      @(negedge clk);
      check("rd_end_devsel", 32'(dev_sel), 32'd1);
      check("rd_end_trdy", 32'(t_rdy), 32'd1);
      check("rd_end_stop", 32'(stop), 32'd1);
      check("rd_end_ad_off", 32'(ad_released()), 32'd1);
      check("rd_end_par", 32'(par), 32'(ep));
      frame = 1'b1; irdy = 1'b1;
   endtask

   // Single-word transfer that the target must disconnect after.
   task automatic disc_xfer(input logic is_wr, input logic [31:0] addr,
                            input logic [3:0] cmd, input logic [31:0] data);
      int w;
      w = int'(addr[9:2]);
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; ad_en = 1'b1; ad_drv = addr; cbe_drv = cmd;
      if (!is_wr) begin
         @(negedge clk);
         ad_en = 1'b0; irdy = 1'b0; cbe_drv = 4'h0;
         #1;
         check("disc_turn_trdy", 32'(t_rdy), 32'd1);
      end
      @(negedge clk);
      check("disc_trdy", 32'(t_rdy), 32'd0);
      check("disc_stop", 32'(stop), 32'd0);
      check("disc_devsel", 32'(dev_sel), 32'd0);
      if (is_wr) begin
         ad_drv = data; cbe_drv = 4'h0; irdy = 1'b0;
         model_mem[w] = data;
      end else begin
         check("disc_rdata", ad_w, model_mem[w]);
      end
      frame = 1'b0;
      for (int h = 0; h < 2; h++) begin
         @(negedge clk);
         ad_en = 1'b0;
         #1;
         check("disc_hold_trdy", 32'(t_rdy), 32'd1);
         check("disc_hold_stop", 32'(stop), 32'd0);
         check("disc_hold_devsel", 32'(dev_sel), 32'd0);
         check("disc_hold_ad_off", 32'(ad_released()), 32'd1);
         irdy = 1'b1; frame = (h == 1);
      end
      @(negedge clk);
      check("disc_end_trdy", 32'(t_rdy), 32'd1);
      check("disc_end_stop", 32'(stop), 32'd1);
      check("disc_end_devsel", 32'(dev_sel), 32'd1);
      check("disc_end_ad_off", 32'(ad_released()), 32'd1);
   endtask

   // Address phase that must not be claimed, followed by a would-be data phase.
   task automatic no_claim(input logic [31:0] addr, input logic [3:0] cmd);
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; ad_en = 1'b1; ad_drv = addr; cbe_drv = cmd;
      @(negedge clk);
      check("nc_devsel", 32'(dev_sel), 32'd1);
      check("nc_trdy", 32'(t_rdy), 32'd1);
      ad_drv = 32'hFFFF_FFFF; cbe_drv = 4'h0; irdy = 1'b0; frame = 1'b1;
      @(negedge clk);
      check("nc_devsel2", 32'(dev_sel), 32'd1);
      irdy = 1'b1; ad_en = 1'b0;
   endtask

   initial begin
      logic [3:0] wcmds [2];
      logic [3:0] rcmds [3];
      logic [31:0] d;
      int start, n;
      logic [1:0] mode;
      wcmds = '{4'b0111, 4'b1111};
      rcmds = '{4'b0110, 4'b1100, 4'b1110};

      rst = 1'b1; frame = 1'b1; irdy = 1'b1; ad_en = 1'b0; ad_drv = 32'h0; cbe_drv = 4'h0;
      repeat (3) @(negedge clk);
      check("rst_trdy", 32'(t_rdy), 32'd1);
      check("rst_stop", 32'(stop), 32'd1);
      check("rst_devsel", 32'(dev_sel), 32'd1);
      check("rst_perr", 32'(perr), 32'd1);
      check("rst_par", 32'(par), 32'd0);
      check("rst_ad_off", 32'(ad_released()), 32'd1);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;

      // fill words 0..254 with nonzero data in one long linear burst
      clear_wr();
      for (int i = 0; i < 255; i++) begin
         wr_data[i] = $urandom | 32'h1;
         wr_wait[i] = ($urandom_range(0, 7) == 0);
      end
      wr_burst(32'h0, 4'b1111, 255);

      // full-word write then linear read
      clear_wr();
      wr_data[0] = 32'h1A2B3C4D; wr_data[1] = 32'hEE33FF55; wr_data[2] = 32'h98765432;
      wr_burst(32'h0, 4'b0111, 3);
      rd_burst(32'h0, 4'b0110, 3);

      // byte enables
      clear_wr();
      wr_data[0] = 32'h0;
      wr_burst(32'h0, 4'b0111, 1);
      wr_data[0] = 32'h1A2B3C4D; wr_be[0] = 4'b1001;
      wr_burst(32'h0, 4'b0111, 1);
      rd_burst(32'h0, 4'b0110, 1);

      // write wait state mid-burst
      clear_wr();
      wr_data[0] = 32'h11110001; wr_data[1] = 32'h22220002; wr_data[2] = 32'h33330003;
      wr_wait[1] = 1'b1;
      wr_burst(32'h20, 4'b0111, 3);
      rd_burst(32'h20, 4'b0110, 4);

      // wrap write (words 3,0) then wrap read from word 1
      clear_wr();
      wr_data[0] = 32'hCAFE0003; wr_data[1] = 32'hBEEF0000;
      wr_burst(32'hE, 4'b0111, 2);
      rd_burst(32'h6, 4'b1110, 5);

      // disconnect at top of window and for reserved modes
      disc_xfer(1'b1, 32'h3FC, 4'b0111, 32'h5A5A00FF);
      disc_xfer(1'b0, 32'h3FC, 4'b0110, 32'h0);
      disc_xfer(1'b1, 32'h13, 4'b1111, 32'h0BAD0004);
      disc_xfer(1'b0, 32'h11, 4'b1100, 32'h0);

      // reset in the middle of a write burst
      @(negedge clk);
      frame = 1'b0; irdy = 1'b1; ad_en = 1'b1; ad_drv = 32'h50; cbe_drv = 4'b0111;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         d = $urandom | 32'h1;
         ad_drv = d; cbe_drv = 4'h0; irdy = 1'b0; frame = 1'b0;
         model_mem[20 + j] = d;
      end
      @(negedge clk);
      check("pre_rst_trdy", 32'(t_rdy), 32'd0);
      ad_drv = $urandom; rst = 1'b1;
      #1;
      check("mid_rst_trdy", 32'(t_rdy), 32'd1);
      check("mid_rst_devsel", 32'(dev_sel), 32'd1);
      check("mid_rst_stop", 32'(stop), 32'd1);
      check("mid_rst_perr", 32'(perr), 32'd1);
      check("mid_rst_par", 32'(par), 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b0; frame = 1'b1; irdy = 1'b1; ad_en = 1'b0;
      rd_burst(32'h50, 4'b0110, 3);

      // decode rejects
      no_claim(32'h400, 4'b0111);
      no_claim(32'h0, 4'b0010);
      rd_burst(32'h0, 4'b0110, 2);

      // randomized bursts
      for (int it = 0; it < 24; it++) begin
         mode  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
         n     = $urandom_range(1, 6);
         start = $urandom_range(0, 200);
         if ($urandom_range(0, 1) == 1) begin
            clear_wr();
            for (int i = 0; i < n; i++) begin
               wr_data[i] = $urandom | 32'h1;
               wr_be[i]   = 4'($urandom);
               wr_wait[i] = ($urandom_range(0, 3) == 0);
            end
            wr_burst({22'h0, 8'(start), mode}, wcmds[$urandom_range(0, 1)], n);
         end else begin
            rd_burst({22'h0, 8'(start), mode}, rcmds[$urandom_range(0, 2)], n);
         end
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
